// File: rtl/wb_rr_arbiter_if.sv
// Signal bundle between wb_rr_arbiter, its masters and the shared RAM slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
  logic [DW-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;

  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  logic [NUM_MASTERS-1:0]        grant_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output grant_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one RAM slave; grant is locked for the whole bus cycle.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 1024
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  wb_rr_arbiter_if.slave bus
);
  localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int IW1 = IW + 1;
  localparam int SW  = DW / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant, grant_nxt;
  logic [IW-1:0]          last, last_nxt;
  logic [IW-1:0]          pick, cand;
  logic [IW1-1:0]         sum;
  logic                   pick_vld;
  logic                   timeout;
  logic                   held;

  logic [AW-1:0]          mux_adr;
  logic [DW-1:0]          mux_dat;
  logic [SW-1:0]          mux_sel;
  logic                   mux_we;
  logic [2:0]             mux_cti;
  logic [1:0]             mux_bte;
  logic                   slv_cyc;
  logic                   resp_ok;

  // Rotating scan starting after the last served master; the lowest offset wins.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      sum = {1'b0, last} + IW1'(i);
      if (sum >= IW1'(NUM_MASTERS)) sum = sum - IW1'(NUM_MASTERS);
      cand = sum[IW-1:0];
      if (bus.wbm_cyc_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign held = |(grant & bus.wbm_cyc_i);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
          last_nxt  = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!held || timeout) begin
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // Any slave response proves the slave is alive and restarts the count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt <= '0;
    end else if (state != BUSY || bus.wbs_ack_i || bus.wbs_err_i || bus.wbs_rty_i) begin
      wd_cnt <= '0;
    end else if (!timeout) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && (wd_cnt == CW'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    mux_adr = '0;
    mux_dat = '0;
    mux_sel = '0;
    mux_we  = 1'b0;
    mux_cti = '0;
    mux_bte = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (grant[m]) begin
        mux_adr = bus.wbm_adr_i[m*AW +: AW];
        mux_dat = bus.wbm_dat_i[m*DW +: DW];
        mux_sel = bus.wbm_sel_i[m*SW +: SW];
        mux_we  = bus.wbm_we_i[m];
        mux_cti = bus.wbm_cti_i[m*3 +: 3];
        mux_bte = bus.wbm_bte_i[m*2 +: 2];
      end
    end
  end

  assign slv_cyc = held & ~timeout;
  // Responses arriving in a reset cycle belong to a transfer that is being abandoned.
  assign resp_ok = slv_cyc & ~wb_rst_i;

  assign bus.wbs_adr_o = mux_adr;
  assign bus.wbs_dat_o = mux_dat;
  assign bus.wbs_sel_o = mux_sel;
  assign bus.wbs_we_o  = mux_we;
  assign bus.wbs_cti_o = mux_cti;
  assign bus.wbs_bte_o = mux_bte;
  assign bus.wbs_cyc_o = slv_cyc;
  assign bus.wbs_stb_o = |(grant & bus.wbm_stb_i) & ~timeout;

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_ack_o = grant & {NUM_MASTERS{bus.wbs_ack_i & resp_ok}};
  assign bus.wbm_rty_o = grant & {NUM_MASTERS{bus.wbs_rty_i & resp_ok}};
  assign bus.wbm_err_o = grant & {NUM_MASTERS{((bus.wbs_err_i & resp_ok) | timeout) & ~wb_rst_i}};
  assign bus.grant_o   = grant;
endmodule
